// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU address/control sequencer: state encoding,
// the minimum column height and a constant-evaluable ceil(log2) helper.
package mcu_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_CONV  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Shorter columns cannot hold a 3-row convolution window.
    localparam int MIN_HEIGHT = 3;

    // Number of bits needed to count 0..value-1 (returns 0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Up-counter that steps on en, returns to zero after reaching limit-1 and
// flags that wrapping step with a combinational wrap pulse. clr wins over en.
module wrap_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    assign wrap  = en && (count_reg == (limit - WIDTH'(1)));
    assign count = count_reg;

    // Next count: clear, wrap to zero on the last value, or step by one.
    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            count_next = wrap ? '0 : (count_reg + WIDTH'(1));
        end
    end

    // Count register, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/mcu_addr_seq.sv
// Address and control sequencer feeding the memory control unit: counts pixel
// writes into a column block, then sweeps the read address for one
// convolution pass followed by a fixed write-back drain.
module mcu_addr_seq #(
    parameter int BITS_ADDR = 10,
    parameter int PIPE_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic                 i_run,
    input  logic [BITS_ADDR-1:0] i_height,
    output logic [BITS_ADDR-1:0] o_WAddr,
    output logic [BITS_ADDR-1:0] o_RAddr,
    output logic                 o_chblk,
    output logic                 o_sop,
    output logic                 o_eop,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    import mcu_pkg::*;

    // Drain counter counts down PIPE_LAT-1..0; at least one bit wide.
    localparam int DRAIN_W = (clog2(PIPE_LAT) > 0) ? clog2(PIPE_LAT) : 1;
    localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);
    localparam logic [BITS_ADDR-1:0] MIN_H      = BITS_ADDR'(MIN_HEIGHT);

    logic [1:0]           state_reg,  state_next;
    logic [BITS_ADDR-1:0] h_reg,      h_next;
    logic [DRAIN_W-1:0]   drain_reg,  drain_next;
    logic                 loaded_reg, loaded_next;
    logic                 err_reg,    err_next;
    logic                 chblk_reg,  chblk_next;
    logic                 sop_reg,    sop_next;
    logic                 eop_reg,    eop_next;
    logic                 busy_reg,   busy_next;
    logic                 done_reg,   done_next;

    logic                 run_accept;
    logic [BITS_ADDR-1:0] height_clamped;
    logic                 w_en, w_wrap;
    logic                 r_en, r_clr, r_wrap;
    logic [BITS_ADDR-1:0] w_count, r_count;

    assign height_clamped = (i_height < MIN_H) ? MIN_H : i_height;

    // A run in IDLE with a loaded block takes priority over a simultaneous write.
    assign run_accept = (state_reg == ST_IDLE) && i_run && loaded_reg;

    // Writes are taken in LOAD, or in IDLE when they start a new block.
    assign w_en  = i_valid && ((state_reg == ST_LOAD) ||
                               ((state_reg == ST_IDLE) && !run_accept));
    assign r_en  = (state_reg == ST_CONV);
    assign r_clr = (state_reg != ST_CONV);

    wrap_counter #(
        .WIDTH (BITS_ADDR)
    ) u_wcnt (
        .clk   (clk),
        .rst   (rst),
        .en    (w_en),
        .clr   (1'b0),
        .limit (h_reg),
        .count (w_count),
        .wrap  (w_wrap)
    );

    wrap_counter #(
        .WIDTH (BITS_ADDR)
    ) u_rcnt (
        .clk   (clk),
        .rst   (rst),
        .en    (r_en),
        .clr   (r_clr),
        .limit (h_reg),
        .count (r_count),
        .wrap  (r_wrap)
    );

    // State transitions, flag updates and strobe decisions for the next cycle.
    always_comb begin
        state_next  = state_reg;
        h_next      = h_reg;
        drain_next  = drain_reg;
        loaded_next = loaded_reg;
        err_next    = err_reg;
        chblk_next  = 1'b0;
        sop_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (run_accept) begin
                    state_next  = ST_CONV;
                    sop_next    = 1'b1;
                    loaded_next = 1'b0;
                    if (i_valid) begin
                        err_next = 1'b1;
                    end
                end else if (i_valid) begin
                    h_next     = height_clamped;
                    state_next = ST_LOAD;
                end else if (i_run) begin
                    err_next = 1'b1;
                end
            end
            ST_LOAD: begin
                if (i_run) begin
                    err_next = 1'b1;
                end
                if (w_wrap) begin
                    chblk_next  = 1'b1;
                    loaded_next = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (i_valid) begin
                    err_next = 1'b1;
                end
                if (r_wrap) begin
                    state_next = ST_DRAIN;
                    drain_next = DRAIN_LAST;
                end
            end
            default: begin
                if (i_valid) begin
                    err_next = 1'b1;
                end
                if (drain_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    drain_next = drain_reg - DRAIN_W'(1);
                end
            end
        endcase
        // The read counter reaches h-1 on the next edge (h is at least 3).
        eop_next  = (state_reg == ST_CONV) && (r_count == (h_reg - BITS_ADDR'(2)));
        done_next = (state_next == ST_DRAIN) && (drain_next == '0);
        busy_next = (state_next != ST_IDLE);
    end

    // Control and strobe registers; every output is taken from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            h_reg      <= MIN_H;
            drain_reg  <= '0;
            loaded_reg <= 1'b0;
            err_reg    <= 1'b0;
            chblk_reg  <= 1'b0;
            sop_reg    <= 1'b0;
            eop_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            h_reg      <= h_next;
            drain_reg  <= drain_next;
            loaded_reg <= loaded_next;
            err_reg    <= err_next;
            chblk_reg  <= chblk_next;
            sop_reg    <= sop_next;
            eop_reg    <= eop_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign o_WAddr = w_count;
    assign o_RAddr = r_count;
    assign o_chblk = chblk_reg;
    assign o_sop   = sop_reg;
    assign o_eop   = eop_reg;
    assign o_busy  = busy_reg;
    assign o_done  = done_reg;
    assign o_err   = err_reg;

endmodule
